branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Parametrised branch resolution stage for the single-cycle core's successor. It evaluates the branch condition for all RV32I/RV64I branch and jump encodings, with signed and unsigned compares. It detects mispredictions against the fetch-time prediction and trains a 2-bit bimodal branch history table (BHT). Results are registered, one cycle after the request, for the PC-select and flush logic; the BHT read port serves the fetch stage.

## Interface
Parameters:
- XLEN, 32, operand/PC width (32 or 64)
- BHT_ENTRIES, 64, number of 2-bit counters; power of two, ≥2
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- valid_i  in  1  resolve request this cycle
- flush_i  in  1  kill in-flight request (same cycle as valid_i)
- br_op_i  in  5  branch op: 00000 beq, 00001 bne, 00100 blt, 00101 bge, 00110 bltu, 00111 bgeu, 01111 jal, 10111 jalr, 10101 no-branch
- rs1_i, rs2_i  in  XLEN  operands
- pc_i  in  XLEN  PC of the resolving instruction
- target_i  in  XLEN  precomputed taken target
- pred_taken_i  in  1  prediction carried from fetch
- fetch_pc_i  in  XLEN  lookup PC
- pred_taken_o  out  1  combinational BHT prediction for fetch_pc_i (counter MSB)
- valid_o  out  1  registered result valid
- taken_o  out  1  resolved direction
- mispredict_o  out  1  taken_o ≠ pred_taken_i
- redirect_pc_o  out  XLEN  correct next PC
- op_err_o  out  1  undefined br_op_i seen
- clr_cnt_i  in  1  synchronous clear of performance counters
- br_cnt_o, mispred_cnt_o  out  CNT_W  conditional-branch count and mispredict count

## Operation
- Conditions (rs1 op rs2):
  - beq: =
  - bne: ≠
  - blt, bge: signed < / ≥
  - bltu, bgeu: unsigned < / ≥
  - jal, jalr: always taken
  - no-branch: never taken
  - Undefined op: not taken, op_err_o=1, no BHT update.
- redirect_pc_o = taken ? target_i : pc_i + 4 (mod 2^XLEN).
- mispredict_o = taken ^ pred_taken_i, for every valid op including jumps and no-branch.
- BHT index = PC[log2(BHT_ENTRIES)+1:2] (same for lookup and update).
- BHT update: only on an accepted conditional branch (valid_i & ~flush_i & op in the six compares).
  - Counter saturates at 00 and 11.
  - taken increments, not-taken decrements.
  - All counters reset to 01 (weakly not-taken).
- Same-cycle read and write to one index: pred_taken_o reflects the old value, with no bypass.
- Performance counters:
  - br_cnt_o increments per accepted conditional branch.
  - mispred_cnt_o increments per accepted conditional branch with mispredict.
  - Both saturate at all-ones.
  - clr_cnt_i has priority over increment in the same cycle.

## Timing
- Latency 1: request at edge N, results valid after edge N+1, held until the next accepted request.
- valid_o is high one cycle per accepted request (valid_i & ~flush_i). Back-to-back requests every cycle are supported.
- When valid_o=0, taken_o, mispredict_o and op_err_o are 0; redirect_pc_o holds its last value.
- BHT update is visible to pred_taken_o the cycle after the request edge.
- Reset values:
  - All outputs 0.
  - Counters 0; BHT all 01.
  - Reset mid-operation drops the in-flight result; the next cycle shows valid_o=0.
- Flush with valid_i: no output, no BHT or counter update.

## Structure
- Package br_pkg:
  - br_op_e enum (nine encodings above)
  - bht_state_e (SNT=00, WNT=01, WT=10, ST=11)
  - is_cond_br() helper
- Sub-module bht_2bit (parameters ENTRIES, XLEN):
  - async-reset counter array
  - one combinational read port, one synchronous update port
- The top holds the comparators, redirect mux, output register and perf counters.

## Test plan
- blt rs1=0xFFFF_FFFF, rs2=1 -> taken_o=1; bltu on the same operands -> taken_o=0; bge -> 0; bgeu -> 1.
- beq taken at pc=0x100, target=0x40, pred_taken_i=0 -> next cycle valid_o=1, taken_o=1, mispredict_o=1, redirect_pc_o=0x40, mispred_cnt_o=1.
- Three taken branches at pc=0x10 -> pred_taken_o for 0x10: 0 after reset, 1 after the first, counter saturates at 11. Then three not-taken -> pred_taken_o returns to 0 after the second.
- valid_i with flush_i=1 (beq, equal operands) -> valid_o=0, br_cnt_o unchanged, BHT unchanged. jal with pred_taken_i=1 -> taken_o=1, mispredict_o=0, no BHT or counter change.
- br_op_i=5'b11111 -> op_err_o=1, taken_o=0, redirect_pc_o=pc_i+4. Also: pc_i=0xFFFF_FFFC not-taken -> redirect_pc_o=0 (wrap).
- rst_n low mid-stream -> all outputs 0 immediately and pred_taken_o=0 for all PCs. clr_cnt_i together with a mispredicting branch -> both counters 0.

Source files
------------

// File: rtl/br_pkg.sv
// Shared branch-op encodings, BHT counter states and the conditional-branch decode helper.
// No timing of its own; pure type and function definitions.
package br_pkg;

    typedef enum logic [4:0] {
        OP_BEQ  = 5'b00000,
        OP_BNE  = 5'b00001,
        OP_BLT  = 5'b00100,
        OP_BGE  = 5'b00101,
        OP_BLTU = 5'b00110,
        OP_BGEU = 5'b00111,
        OP_JAL  = 5'b01111,
        OP_JALR = 5'b10111,
        OP_NOBR = 5'b10101
    } br_op_e;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_e;

    function automatic logic is_cond_br(input logic [4:0] op);
        logic res;
        res = 1'b0;
        case (op)
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// Bimodal table of 2-bit saturating counters: combinational read, update lands on the next edge.
// No backpressure; a read and write to one index in the same cycle returns the pre-update value.
module bht_2bit
    import br_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] rd_pc_i,
    output logic            rd_taken_o,
    input  logic            upd_vld_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i
);
    localparam int IDX_W = $clog2(ENTRIES);

    bht_state_e cnt_q [ENTRIES];
    bht_state_e cnt_d [ENTRIES];
    bht_state_e cnt_nxt;

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] upd_idx;

    assign rd_idx     = rd_pc_i[IDX_W+1:2];
    assign upd_idx    = upd_pc_i[IDX_W+1:2];
    assign rd_taken_o = cnt_q[rd_idx] inside {WT, ST};

    always_comb begin
        cnt_d = cnt_q;
        case (cnt_q[upd_idx])
            SNT:     cnt_nxt = upd_taken_i ? WNT : SNT;
            WNT:     cnt_nxt = upd_taken_i ? WT  : SNT;
            WT:      cnt_nxt = upd_taken_i ? ST  : WNT;
            default: cnt_nxt = upd_taken_i ? ST  : WT;
        endcase
        if (upd_vld_i) begin
            cnt_d[upd_idx] = cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= WNT;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // PC bits outside the index field do not select a counter.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{rd_pc_i[1:0], rd_pc_i[XLEN-1:IDX_W+2],
                              upd_pc_i[1:0], upd_pc_i[XLEN-1:IDX_W+2]};

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves branch direction and next PC, flags mispredicts, trains the BHT, counts branches.
// Latency 1 cycle; no backpressure, a request may be accepted every cycle.
module branch_resolve_unit
    import br_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic             flush_i,
    input  logic [4:0]       br_op_i,
    input  logic [XLEN-1:0]  rs1_i,
    input  logic [XLEN-1:0]  rs2_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  target_i,
    input  logic             pred_taken_i,
    input  logic [XLEN-1:0]  fetch_pc_i,
    output logic             pred_taken_o,
    output logic             valid_o,
    output logic             taken_o,
    output logic             mispredict_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic             op_err_o,
    input  logic             clr_cnt_i,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);
    typedef struct packed {
        logic            vld;
        logic            taken;
        logic            mispredict;
        logic            op_err;
        logic [XLEN-1:0] redirect_pc;
    } res_t;

    res_t             res_d, res_q;
    logic [CNT_W-1:0] br_cnt_d, br_cnt_q;
    logic [CNT_W-1:0] mispred_cnt_d, mispred_cnt_q;
    logic             accept, cond_br, taken, op_err, mispredict;
    logic             eq, lt_s, lt_u;

    assign accept     = valid_i & ~flush_i;
    assign cond_br    = is_cond_br(br_op_i);
    assign mispredict = taken ^ pred_taken_i;

    always_comb begin
        eq     = (rs1_i == rs2_i);
        lt_s   = ($signed(rs1_i) < $signed(rs2_i));
        lt_u   = (rs1_i < rs2_i);
        taken  = 1'b0;
        op_err = 1'b0;
        case (br_op_i)
            OP_BEQ:          taken = eq;
            OP_BNE:          taken = ~eq;
            OP_BLT:          taken = lt_s;
            OP_BGE:          taken = ~lt_s;
            OP_BLTU:         taken = lt_u;
            OP_BGEU:         taken = ~lt_u;
            OP_JAL, OP_JALR: taken = 1'b1;
            OP_NOBR:         taken = 1'b0;
            default:         op_err = 1'b1;
        endcase
    end

    // Flags drop to zero between results; the redirect PC is held for the PC-select mux.
    always_comb begin
        res_d            = res_q;
        res_d.vld        = accept;
        res_d.taken      = accept & taken;
        res_d.mispredict = accept & mispredict;
        res_d.op_err     = accept & op_err;
        if (accept) begin
            res_d.redirect_pc = taken ? target_i : pc_i + XLEN'(4);
        end
    end

    always_comb begin
        br_cnt_d      = br_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (clr_cnt_i) begin
            br_cnt_d      = '0;
            mispred_cnt_d = '0;
        end else if (accept && cond_br) begin
            if (!(&br_cnt_q)) begin
                br_cnt_d = br_cnt_q + CNT_W'(1);
            end
            if (mispredict && !(&mispred_cnt_q)) begin
                mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q         <= '0;
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            res_q         <= res_d;
            br_cnt_q      <= br_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign valid_o       = res_q.vld;
    assign taken_o       = res_q.taken;
    assign mispredict_o  = res_q.mispredict;
    assign op_err_o      = res_q.op_err;
    assign redirect_pc_o = res_q.redirect_pc;
    assign br_cnt_o      = br_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

    bht_2bit #(
        .ENTRIES (BHT_ENTRIES),
        .XLEN    (XLEN)
    ) u_bht (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_pc_i     (fetch_pc_i),
        .rd_taken_o  (pred_taken_o),
        .upd_vld_i   (accept & cond_br),
        .upd_pc_i    (pc_i),
        .upd_taken_i (taken)
    );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized and directed stimulus against a behavioural model of branch_resolve_unit.
module tb_branch_resolve_unit;
    localparam int ENT = 64;
    localparam longint CMAX = 64'hFFFF_FFFF;

    logic        clk, rst_n, valid_i, flush_i, pred_taken_i, clr_cnt_i;
    logic [4:0]  br_op_i;
    logic [31:0] rs1_i, rs2_i, pc_i, target_i, fetch_pc_i;
    logic        pred_taken_o, valid_o, taken_o, mispredict_o, op_err_o;
    logic [31:0] redirect_pc_o, br_cnt_o, mispred_cnt_o;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_on  = 0;

    // Behavioural model state
    int          m_bht [ENT];
    bit          m_valid, m_taken, m_mis, m_err;
    logic [31:0] m_redir;
    longint      m_br, m_mp;

    logic [4:0] ops [9] = '{5'b00000, 5'b00001, 5'b00100, 5'b00101, 5'b00110,
                            5'b00111, 5'b01111, 5'b10111, 5'b10101};

    branch_resolve_unit #(.XLEN(32), .BHT_ENTRIES(ENT), .CNT_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_i       (valid_i),
        .flush_i       (flush_i),
        .br_op_i       (br_op_i),
        .rs1_i         (rs1_i),
        .rs2_i         (rs2_i),
        .pc_i          (pc_i),
        .target_i      (target_i),
        .pred_taken_i  (pred_taken_i),
        .fetch_pc_i    (fetch_pc_i),
        .pred_taken_o  (pred_taken_o),
        .valid_o       (valid_o),
        .taken_o       (taken_o),
        .mispredict_o  (mispredict_o),
        .redirect_pc_o (redirect_pc_o),
        .op_err_o      (op_err_o),
        .clr_cnt_i     (clr_cnt_i),
        .br_cnt_o      (br_cnt_o),
        .mispred_cnt_o (mispred_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int bidx(input logic [31:0] p);
        return int'((p >> 2) % ENT);
    endfunction

    function automatic bit ref_taken(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output bit defined, output bit cond);
        bit t;
        t = 0; defined = 1; cond = 0;
        case (op)
            5'b00000: begin cond = 1; t = (a == b); end
            5'b00001: begin cond = 1; t = (a != b); end
            5'b00100: begin cond = 1; t = (int'(a) <  int'(b)); end
            5'b00101: begin cond = 1; t = (int'(a) >= int'(b)); end
            5'b00110: begin cond = 1; t = (longint'(a) <  longint'(b)); end
            5'b00111: begin cond = 1; t = (longint'(a) >= longint'(b)); end
            5'b01111, 5'b10111: t = 1;
            5'b10101: t = 0;
            default: defined = 0;
        endcase
        return t;
    endfunction

    function automatic void model_reset();
        m_valid = 0; m_taken = 0; m_mis = 0; m_err = 0; m_redir = '0;
        m_br = 0; m_mp = 0;
        for (int i = 0; i < ENT; i++) m_bht[i] = 1;
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, return #1 after it.
    task automatic req(input bit v, input bit f, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pc, input logic [31:0] tgt,
                       input bit pt, input bit clr);
        bit tk, def, cond, acc;
        int ix;
        valid_i = v; flush_i = f; br_op_i = op; rs1_i = a; rs2_i = b;
        pc_i = pc; target_i = tgt; pred_taken_i = pt; clr_cnt_i = clr;
        @(posedge clk);
        tk  = ref_taken(op, a, b, def, cond);
        acc = v && !f;
        m_valid = acc;
        m_taken = acc && tk;
        m_mis   = acc && (tk != pt);
        m_err   = acc && !def;
        if (acc) m_redir = tk ? tgt : pc + 32'd4;
        if (acc && cond) begin
            ix = bidx(pc);
            if (tk) m_bht[ix] = (m_bht[ix] == 3) ? 3 : m_bht[ix] + 1;
            else    m_bht[ix] = (m_bht[ix] == 0) ? 0 : m_bht[ix] - 1;
        end
        if (clr) begin
            m_br = 0; m_mp = 0;
        end else if (acc && cond) begin
            if (m_br < CMAX) m_br++;
            if (tk != pt && m_mp < CMAX) m_mp++;
        end
        #1;
    endtask

    // Called #1 after an edge; releases reset before the following edge.
    task automatic do_reset();
        rst_n = 0; valid_i = 0; flush_i = 0; clr_cnt_i = 0;
        model_reset();
        #1;
        check("rst_valid", valid_o, 0);
        check("rst_taken", taken_o, 0);
        check("rst_redirect", redirect_pc_o, 0);
        check("rst_br_cnt", br_cnt_o, 0);
        check("rst_mp_cnt", mispred_cnt_o, 0);
        for (int k = 0; k < 4; k++) begin
            fetch_pc_i = $urandom;
            #1;
            check("rst_pred", pred_taken_o, 0);
        end
        #2;
        rst_n = 1;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("valid_o", valid_o, m_valid);
            check("taken_o", taken_o, m_taken);
            check("mispredict_o", mispredict_o, m_mis);
            check("op_err_o", op_err_o, m_err);
            check("redirect_pc_o", redirect_pc_o, m_redir);
            check("br_cnt_o", br_cnt_o, m_br);
            check("mispred_cnt_o", mispred_cnt_o, m_mp);
            check("pred_taken_o", pred_taken_o, m_bht[bidx(fetch_pc_i)] >= 2);
        end
    end

    initial begin
        rst_n = 1; valid_i = 0; flush_i = 0; br_op_i = '0; rs1_i = '0; rs2_i = '0;
        pc_i = '0; target_i = '0; pred_taken_i = 0; clr_cnt_i = 0; fetch_pc_i = 32'h10;
        #2;
        rst_n = 0;
        model_reset();
        chk_on = 1;
        #1;
        check("init_valid", valid_o, 0);
        check("init_pred", pred_taken_o, 0);
        #20;
        rst_n = 1;

        // Signed vs unsigned compares
        req(1, 0, 5'b00100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h280, 0, 0);
        check("blt_signed", taken_o, 1);
        req(1, 0, 5'b00110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h280, 0, 0);
        check("bltu_unsigned", taken_o, 0);
        req(1, 0, 5'b00101, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h280, 0, 0);
        check("bge_signed", taken_o, 0);
        req(1, 0, 5'b00111, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h280, 0, 0);
        check("bgeu_unsigned", taken_o, 1);

        // Mispredicted beq after a counter clear
        req(0, 0, 5'b00000, 0, 0, 0, 0, 0, 1);
        req(1, 0, 5'b00000, 32'd5, 32'd5, 32'h100, 32'h40, 0, 0);
        check("beq_valid", valid_o, 1);
        check("beq_taken", taken_o, 1);
        check("beq_mispredict", mispredict_o, 1);
        check("beq_redirect", redirect_pc_o, 32'h40);
        check("beq_mp_cnt", mispred_cnt_o, 1);

        // BHT training at 0x10
        fetch_pc_i = 32'h10;
        #1;
        check("bht_init", pred_taken_o, 0);
        req(1, 0, 5'b00000, 32'd7, 32'd7, 32'h10, 32'h80, 0, 0);
        check("bht_t1", pred_taken_o, 1);
        req(1, 0, 5'b00000, 32'd7, 32'd7, 32'h10, 32'h80, 0, 0);
        req(1, 0, 5'b00000, 32'd7, 32'd7, 32'h10, 32'h80, 0, 0);
        check("bht_t3", pred_taken_o, 1);
        req(1, 0, 5'b00000, 32'd7, 32'd8, 32'h10, 32'h80, 0, 0);
        check("bht_sat_nt1", pred_taken_o, 1);
        req(1, 0, 5'b00000, 32'd7, 32'd8, 32'h10, 32'h80, 0, 0);
        check("bht_nt2", pred_taken_o, 0);
        req(1, 0, 5'b00000, 32'd7, 32'd8, 32'h10, 32'h80, 0, 0);
        check("bht_nt3", pred_taken_o, 0);
        check("br_cnt_7", br_cnt_o, 7);
        check("mp_cnt_4", mispred_cnt_o, 4);

        // Flush, jump, undefined op and PC wrap
        req(1, 1, 5'b00000, 32'd3, 32'd3, 32'h10, 32'h80, 0, 0);
        check("flush_valid", valid_o, 0);
        check("flush_br_cnt", br_cnt_o, 7);
        check("flush_pred", pred_taken_o, 0);
        req(1, 0, 5'b01111, 32'd0, 32'd0, 32'h400, 32'h800, 1, 0);
        check("jal_taken", taken_o, 1);
        check("jal_mispredict", mispredict_o, 0);
        check("jal_br_cnt", br_cnt_o, 7);
        check("jal_redirect", redirect_pc_o, 32'h800);
        req(1, 0, 5'b11111, 32'd1, 32'd1, 32'h300, 32'h900, 0, 0);
        check("undef_err", op_err_o, 1);
        check("undef_taken", taken_o, 0);
        check("undef_redirect", redirect_pc_o, 32'h304);
        req(1, 0, 5'b00001, 32'd4, 32'd4, 32'hFFFF_FFFC, 32'h10, 0, 0);
        check("wrap_redirect", redirect_pc_o, 32'h0);

        // Reset mid-stream, then clear racing a mispredict
        req(1, 0, 5'b00000, 32'd1, 32'd1, 32'h20, 32'h60, 0, 0);
        check("pre_rst_valid", valid_o, 1);
        do_reset();
        req(1, 0, 5'b00000, 32'd1, 32'd1, 32'h20, 32'h60, 0, 0);
        check("pre_clr_mp", mispred_cnt_o, 1);
        req(1, 0, 5'b00000, 32'd1, 32'd1, 32'h20, 32'h60, 0, 1);
        check("clr_br_cnt", br_cnt_o, 0);
        check("clr_mp_cnt", mispred_cnt_o, 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [4:0]  op;
            logic [31:0] a, b, pc;
            op = ($urandom_range(0, 9) == 9) ? 5'($urandom) : ops[$urandom_range(0, 8)];
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            pc = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            fetch_pc_i = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            req($urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0, op, a, b, pc, $urandom,
                1'($urandom), $urandom_range(0, 49) == 0);
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        valid_i = 0;
        @(posedge clk);
        chk_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
